// File: rtl/present_decipher.sv
// Iterative 16-bit PRESENT-style decipher: one whitening step, then seven inverse rounds,
// one per clock, with valid/ready handshakes on both the ciphertext and plaintext sides.

module key_scheduler #(
    parameter int KEY_W  = 20,
    parameter int ROUNDS = 7
) (
    input  logic [KEY_W-1:0]             key,
    output logic [ROUNDS:0][KEY_W-1:0]   round_keys
);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [KEY_W-1:0] key_walk;

    // Each key is the previous one rotated right by 5, its top nibble passed through the
    // S-box, and the round index folded into bits [7:4].
    // NOTE: every always_comb output gets a default before any conditional or loop so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        key_walk      = key;
        round_keys    = '0;
        round_keys[0] = key;
        for (int i = 1; i <= ROUNDS; i++) begin
            key_walk        = {key_walk[4:0], key_walk[KEY_W-1:5]};
            key_walk[19:16] = sbox(key_walk[19:16]);
            key_walk[7:4]   = key_walk[7:4] ^ 4'(i);
            round_keys[i]   = key_walk;
        end
    end

endmodule

module present_decipher #(
    parameter int BLOCK_W = 16,
    parameter int KEY_W   = 20,
    parameter int ROUNDS  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] ctext,
    input  logic [KEY_W-1:0]   master_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ptext,
    output logic               busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WHITEN = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]                fsm;
    logic [BLOCK_W-1:0]        state_q;
    logic [KEY_W-1:0]          key_q;
    logic [2:0]                rnd;
    logic [ROUNDS:0][KEY_W-1:0] round_keys;
    logic [BLOCK_W-1:0]        round_out;

    key_scheduler #(.KEY_W(KEY_W), .ROUNDS(ROUNDS)) u_keys (
        .key        (key_q),
        .round_keys (round_keys)
    );

    // The bit permutation is its own inverse, so this serves both directions.
    function automatic logic [15:0] inv_p(input logic [15:0] x);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 15; i++) y[(4 * i) % 15] = x[i];
        y[15] = x[15];
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] inv_s(input logic [15:0] x);
        return {inv_sbox(x[15:12]), inv_sbox(x[11:8]), inv_sbox(x[7:4]), inv_sbox(x[3:0])};
    endfunction

    always_comb begin
        round_out = inv_s(inv_p(state_q)) ^ round_keys[rnd][KEY_W-1:4];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, matching the hardware it describes.
    // NOTE: the reset branch clears every register, key included, so a mid-operation
    // reset leaves nothing of the aborted block behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd     <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        key_q   <= master_key;
                        state_q <= ctext;
                        fsm     <= WHITEN;
                    end
                end
                WHITEN: begin
                    state_q <= state_q ^ round_keys[ROUNDS][KEY_W-1:4];
                    rnd     <= 3'(ROUNDS - 1);
                    fsm     <= ROUND;
                end
                ROUND: begin
                    state_q <= round_out;
                    if (rnd == 3'd0) fsm <= DONE;
                    else             rnd <= rnd - 3'd1;
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // in_ready also looks at rst directly so it stays low for the whole reset pulse.
    assign in_ready  = (fsm == IDLE) && !rst;
    assign out_valid = (fsm == DONE);
    assign ptext     = out_valid ? state_q : '0;
    assign busy      = (fsm == WHITEN) || (fsm == ROUND);

endmodule

// File: tb/tb_present_decipher.sv
// Round-trip bench: plaintexts are enciphered by a behavioural model and the
// decipher must return them, with handshake, latency, backpressure and reset checks.

module tb_present_decipher;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ctext;
    logic [19:0] master_key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ptext;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    present_decipher dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ctext      (ctext),
        .master_key (master_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ptext      (ptext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference cipher, computed from the algorithm's rules with plain arithmetic.
    int sbox_tbl[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    function automatic int next_key(input int k, input int idx);
        int r;
        r = ((k << 15) | (k >> 5)) & 'hFFFFF;
        r = (r & 'h0FFFF) | (sbox_tbl[(r >> 16) & 'hF] << 16);
        return r ^ ((idx & 'hF) << 4);
    endfunction

    function automatic int sub_layer(input int s);
        int r = 0;
        for (int n = 0; n < 4; n++) r |= sbox_tbl[(s >> (4 * n)) & 'hF] << (4 * n);
        return r;
    endfunction

    function automatic int perm_layer(input int s);
        int r = 0;
        for (int i = 0; i < 16; i++)
            if ((s >> i) & 1) r |= 1 << ((i == 15) ? 15 : (4 * i) % 15);
        return r;
    endfunction

    function automatic logic [15:0] encipher(input logic [15:0] pt, input logic [19:0] key);
        int rk[8];
        int s;
        rk[0] = int'(key);
        for (int i = 1; i < 8; i++) rk[i] = next_key(rk[i-1], i);
        s = int'(pt);
        for (int r = 0; r < 7; r++) s = perm_layer(sub_layer(s ^ (rk[r] >> 4)));
        s = s ^ (rk[7] >> 4);
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic abort_run(input string why);
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", why, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "stopping on expired wait bound");
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) abort_run("in_ready_wait");
    endtask

    // Sends one block, optionally pokes in_valid mid-run, stalls out_ready, then drains.
    task automatic run_block(input logic [19:0] key, input logic [15:0] pt,
                             input int stall, input bit inject);
        logic [15:0] ct;
        int n;
        ct = encipher(pt, key);
        wait_idle();
        master_key = key;
        ctext      = ct;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        ctext      = 16'($urandom);
        master_key = 20'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (inject && n == 3) begin
                in_valid = 1'b1;
                ctext    = ~ct;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!out_valid) abort_run("out_valid_wait");
        check("latency", 32'(n), 32'd8);
        check("ptext", 32'(ptext), 32'(pt));
        check("busy_in_done", 32'(busy), 32'd0);
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            if (s % 3 == 1) begin
                in_valid = 1'b1;
                ctext    = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_ptext", 32'(ptext), 32'(pt));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_ptext", 32'(ptext), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Accepts a block and asserts reset once the round counter has reached 3.
    task automatic reset_mid_run(input logic [19:0] key, input logic [15:0] pt);
        wait_idle();
        master_key = key;
        ctext      = encipher(pt, key);
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_ptext", 32'(ptext), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_out_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ctext      = '0;
        master_key = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ptext", 32'(ptext), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);

        // out_ready outside DONE must have no effect.
        out_ready = 1'b1;
        run_block(20'h00000, 16'h0000, 0, 1'b0);
        out_ready = 1'b0;
        run_block(20'hFFFFF, 16'hFFFF, 0, 1'b0);
        run_block(20'hA5C3E, 16'h1234, 0, 1'b0);
        run_block(20'h3C5A1, 16'hBEEF, 20, 1'b0);
        run_block(20'h0F0F0, 16'h8001, 2, 1'b1);
        reset_mid_run(20'h12345, 16'hCAFE);
        run_block(20'h54321, 16'h7E57, 1, 1'b0);

        for (int t = 0; t < 2000; t++) begin
            run_block(20'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
